// File: rtl/start_token_dispatcher.sv
// ---- start_token_dispatcher: FIFO read side that issues one ap_ctrl_hs start per token ----
// ---- and tracks in-flight / completed PE tasks.                                rev 1.0 ----
`default_nettype none

module start_token_dispatcher #(
  parameter int DATA_WIDTH      = 1,
  parameter int MAX_OUTSTANDING = 2,
  parameter int CNT_WIDTH       = 32
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  en,
  input  logic                  if_empty_n,
  output logic                  if_read,
  input  logic [DATA_WIDTH-1:0] if_dout,
  output logic                  pe_ap_start,
  output logic [DATA_WIDTH-1:0] pe_token,
  input  logic                  pe_ap_ready,
  input  logic                  pe_ap_done,
  output logic [3:0]            outstanding,
  output logic [CNT_WIDTH-1:0]  tasks_done,
  output logic                  busy,
  output logic                  err_sticky
);

  localparam logic [3:0]           MAX_OUT = 4'(MAX_OUTSTANDING);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_START = 1'b1
  } state_t;

  state_t     state;
  logic       accept;
  logic [3:0] out_eff;

  assign if_read = (state == S_IDLE) && en && if_empty_n && (outstanding < MAX_OUT);
  assign busy    = (state != S_IDLE) || (outstanding != 4'd0);
  assign accept  = (state == S_START) && pe_ap_ready;
  // A start accepted on this edge counts before a same-edge done is retired.
  assign out_eff = outstanding + {3'b000, accept};

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state       <= S_IDLE;
      pe_ap_start <= 1'b0;
      pe_token    <= '0;
      outstanding <= 4'd0;
      tasks_done  <= '0;
      err_sticky  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (if_read) begin
            state       <= S_START;
            pe_ap_start <= 1'b1;
            pe_token    <= if_dout;
          end
        end
        S_START: begin
          if (pe_ap_ready) begin
            state       <= S_IDLE;
            pe_ap_start <= 1'b0;
          end
        end
        default: begin
          state       <= S_IDLE;
          pe_ap_start <= 1'b0;
        end
      endcase

      if (pe_ap_done) begin
        if (out_eff != 4'd0) begin
          outstanding <= out_eff - 4'd1;
          tasks_done  <= tasks_done + CNT_ONE;
        end else begin
          outstanding <= out_eff;
          err_sticky  <= 1'b1;
        end
      end else begin
        outstanding <= out_eff;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_start_token_dispatcher.sv
// ---- tb_start_token_dispatcher: directed checks of the start token dispatcher. rev 1.0 ----
`default_nettype none

module tb_start_token_dispatcher;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       if_empty_n;
  logic       if_read;
  logic [3:0] if_dout;
  logic       pe_ap_start;
  logic [3:0] pe_token;
  logic       pe_ap_ready;
  logic       pe_ap_done;
  logic [3:0] outstanding;
  logic [3:0] tasks_done;
  logic       busy;
  logic       err_sticky;

  logic [3:0] fifo[$];
  int         pops;
  int         base;
  int         checks;
  int         failures;

  start_token_dispatcher #(
    .DATA_WIDTH     (4),
    .MAX_OUTSTANDING(2),
    .CNT_WIDTH      (4)
  ) dut (
    .ap_clk     (clk),
    .ap_rst_n   (rst_n),
    .en         (en),
    .if_empty_n (if_empty_n),
    .if_read    (if_read),
    .if_dout    (if_dout),
    .pe_ap_start(pe_ap_start),
    .pe_token   (pe_token),
    .pe_ap_ready(pe_ap_ready),
    .pe_ap_done (pe_ap_done),
    .outstanding(outstanding),
    .tasks_done (tasks_done),
    .busy       (busy),
    .err_sticky (err_sticky)
  );

  always #5 clk = ~clk;

  task automatic refresh();
    if_empty_n = (fifo.size() != 0);
    if_dout    = (fifo.size() != 0) ? fifo[0] : 4'h0;
  endtask

  task automatic push(input logic [3:0] v);
    fifo.push_back(v);
    refresh();
  endtask

  // FIFO model: pops the head on any edge where the DUT strobed if_read.
  task automatic tick();
    logic p;
    #1;
    p = if_read;
    @(posedge clk);
    #1;
    if (p && fifo.size() != 0) begin
      void'(fifo.pop_front());
      pops++;
    end
    refresh();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0; failures = 0; pops = 0;
    rst_n = 1'b0; en = 1'b0; pe_ap_ready = 1'b0; pe_ap_done = 1'b0;
    refresh();
    tick(); tick();
    chk("rst_if_read", 32'(if_read), 0);
    chk("rst_start", 32'(pe_ap_start), 0);
    chk("rst_token", 32'(pe_token), 0);
    chk("rst_outstanding", 32'(outstanding), 0);
    chk("rst_tasks_done", 32'(tasks_done), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(err_sticky), 0);
    rst_n = 1'b1;
    tick();

    // 1: single token, PE ready at once, done 5 cycles later
    en = 1'b1; pe_ap_ready = 1'b1;
    push(4'h1);
    #1 chk("t1_if_read", 32'(if_read), 1);
    tick();
    chk("t1_start", 32'(pe_ap_start), 1);
    chk("t1_token", 32'(pe_token), 1);
    chk("t1_if_read_start", 32'(if_read), 0);
    tick();
    pe_ap_ready = 1'b0;
    chk("t1_start_low", 32'(pe_ap_start), 0);
    chk("t1_outstanding", 32'(outstanding), 1);
    chk("t1_busy", 32'(busy), 1);
    chk("t1_pops", 32'(pops), 1);
    tick(); tick(); tick(); tick();
    pe_ap_done = 1'b1;
    tick();
    pe_ap_done = 1'b0;
    chk("t1_out_done", 32'(outstanding), 0);
    chk("t1_tasks_done", 32'(tasks_done), 1);
    chk("t1_busy_done", 32'(busy), 0);

    // 2: four tokens, cap of two outstanding
    pe_ap_ready = 1'b1;
    push(4'h2); push(4'h3); push(4'h4); push(4'h5);
    tick(); tick(); tick(); tick();
    chk("t2_outstanding", 32'(outstanding), 2);
    chk("t2_pops", 32'(pops), 3);
    tick(); tick(); tick();
    chk("t2_pops_capped", 32'(pops), 3);
    chk("t2_if_read_capped", 32'(if_read), 0);
    chk("t2_start_capped", 32'(pe_ap_start), 0);
    pe_ap_done = 1'b1;
    tick();
    pe_ap_done = 1'b0;
    pe_ap_ready = 1'b0;
    chk("t2_out_after_done", 32'(outstanding), 1);
    chk("t2_tasks_done", 32'(tasks_done), 2);
    #1 chk("t2_if_read_resume", 32'(if_read), 1);
    tick();
    chk("t2_third_pop", 32'(pops), 4);
    chk("t2_third_token", 32'(pe_token), 4);

    // 3: PE stalls ready for 10 cycles
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t3_start_hold", 32'(pe_ap_start), 1);
      chk("t3_token_hold", 32'(pe_token), 4);
      chk("t3_no_read", 32'(if_read), 0);
    end
    chk("t3_pops", 32'(pops), 4);

    // 4: ready and done on the same edge
    en = 1'b0; pe_ap_ready = 1'b1; pe_ap_done = 1'b1;
    tick();
    pe_ap_ready = 1'b0; pe_ap_done = 1'b0;
    chk("t4_outstanding", 32'(outstanding), 1);
    chk("t4_tasks_done", 32'(tasks_done), 3);
    chk("t4_start_low", 32'(pe_ap_start), 0);
    chk("t4_no_pop_en0", 32'(if_read), 0);
    pe_ap_done = 1'b1;
    tick();
    chk("t4_drain_out", 32'(outstanding), 0);
    chk("t4_drain_tasks", 32'(tasks_done), 4);

    // 5: spurious done, then reset while in S_START
    tick();
    pe_ap_done = 1'b0;
    chk("t5_err", 32'(err_sticky), 1);
    chk("t5_out_unch", 32'(outstanding), 0);
    chk("t5_tasks_unch", 32'(tasks_done), 4);
    en = 1'b1;
    tick();
    chk("t5_start_before_rst", 32'(pe_ap_start), 1);
    chk("t5_token_before_rst", 32'(pe_token), 5);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_start", 32'(pe_ap_start), 0);
    chk("t5_rst_token", 32'(pe_token), 0);
    chk("t5_rst_out", 32'(outstanding), 0);
    chk("t5_rst_tasks", 32'(tasks_done), 0);
    chk("t5_rst_err", 32'(err_sticky), 0);
    chk("t5_rst_busy", 32'(busy), 0);
    tick();
    rst_n = 1'b1;

    // 6: completed-task counter wraps at 16
    pe_ap_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      push(4'(i));
      tick(); tick();
      pe_ap_done = 1'b1;
      tick();
      pe_ap_done = 1'b0;
    end
    chk("t6_tasks_15", 32'(tasks_done), 15);
    push(4'hF);
    tick(); tick();
    pe_ap_done = 1'b1;
    tick();
    pe_ap_done = 1'b0;
    chk("t6_tasks_wrap", 32'(tasks_done), 0);
    chk("t6_out_zero", 32'(outstanding), 0);
    chk("t6_no_err", 32'(err_sticky), 0);

    // 6b: en toggled low mid-burst
    base = pops;
    push(4'hA); push(4'hB); push(4'hC);
    #1 chk("t6_if_read_a", 32'(if_read), 1);
    tick();
    chk("t6_token_a", 32'(pe_token), 4'hA);
    en = 1'b0;
    tick();
    chk("t6_start_completes", 32'(outstanding), 1);
    tick(); tick(); tick();
    chk("t6_no_read_en0", 32'(if_read), 0);
    chk("t6_pops_en0", 32'(pops - base), 1);
    en = 1'b1;
    #1 chk("t6_if_read_resume", 32'(if_read), 1);
    tick();
    chk("t6_token_b", 32'(pe_token), 4'hB);
    chk("t6_pops_resume", 32'(pops - base), 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
